uart_sync_fifo: RTL
===================

UART_SYNC_FIFO -- requirements
Module: uart_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each stored word in bits.
REQ-002 SHALL have parameter DEPTH, default FIFO_DEPTH from definitions_pkg: entry count; power of two, at least 4.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2: almost_full threshold.
REQ-004 SHALL have parameter AE_THRESH, default 2: almost_empty threshold.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  clock; rstN  input  1  reset.
REQ-006 SHALL have flush  input  1: synchronous empty request.
REQ-007 SHALL have wr  input  1 and wr_data  input  DATA_W: push request and push data.
REQ-008 SHALL have rd  input  1: pop request, or acknowledge of the head word in FWFT mode.
REQ-009 SHALL have rd_data  output  DATA_W and rd_valid  output  1: read data and its qualifier.
REQ-010 SHALL have full, empty, almost_full, almost_empty  output  1 each: status flags.
REQ-011 SHALL have count  output  $clog2(DEPTH)+1: current occupancy.
REQ-012 SHALL have overflow, underflow  output  1 each: sticky error flags.
REQ-013 SHALL have clr_err  input  1: clears both sticky error flags.

Function
REQ-014 SHALL accept a push when wr and (!full or pop accepted in the same cycle).
REQ-015 SHALL accept a pop when rd and !empty.
REQ-016 SHALL keep write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH without extra logic.
REQ-017 SHALL update count as count + push - pop; both events in one cycle leave count unchanged.
REQ-018 SHALL register flags from the next-state count: full at count==DEPTH; empty at count==0; almost_full at count>=AF_THRESH; almost_empty at count<=AE_THRESH.
REQ-019 SHALL treat wr on full with rd as a valid push and pop; the pointers advance and full stays asserted.
REQ-020 SHALL treat wr and rd on empty as a push only; the read is ignored and underflow sets.
REQ-021 SHALL set overflow on wr while full without rd; the data is dropped and state is unchanged.
REQ-022 SHALL set underflow on rd while empty.
REQ-023 SHALL clear overflow and underflow on clr_err; a new error in the same cycle wins and the flag stays set.
REQ-024 SHALL, on flush, zero the pointers and count, set empty and almost_empty, and clear full, almost_full and rd_valid in the next cycle.
REQ-025 SHALL give flush priority over wr and rd in the same cycle and SHALL leave the error flags unchanged on flush.
REQ-026 SHALL operate in standard mode, without FWFT: rd_data is registered, and rd_valid pulses one cycle after an accepted pop with the popped word.

Reset
REQ-027 SHALL, while rstN is low, hold pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-028 SHALL NOT reset the storage array; contents after reset are don't-care.
REQ-029 SHALL abort any operation in progress when reset asserts mid-operation; the first push after reset release is stored at address 0.

Configuration
REQ-030 SHALL, with UART_FIFO_FWFT_EN defined, operate in first-word-fall-through mode: rd_valid = !empty, rd_data shows the head word, rd acknowledges it, and a push into an empty FIFO appears on rd_data/rd_valid one cycle later.
REQ-031 SHALL, with UART_FIFO_FWFT_EN undefined, operate in standard mode per REQ-026; the port list is identical in both modes.

Structure
REQ-032 SHALL take FIFO_DEPTH and the default data width UART_DATA_W from definitions_pkg.
REQ-033 SHALL place storage in sub-module fifo_mem: simple dual-port, one write port and one read port, write enabled by an accepted push.
REQ-034 SHALL keep control, flags and error logic in uart_sync_fifo.

Verification
REQ-035 SHALL cover fill then drain: DEPTH=16, push 0x00..0x0F -> full=1 and count=16, and the pops return 0x00..0x0F in order; almost_full asserts at count=14 and almost_empty at count=2.
REQ-036 SHALL cover overflow: a push of 0xAA while full without rd -> overflow=1, count stays 16, 0xAA is never read; clr_err -> overflow=0 in the next cycle.
REQ-037 SHALL cover simultaneous events: wr+rd on full -> count=16 and the head advances; wr+rd on empty -> count=1 and underflow=1.
REQ-038 SHALL cover wrap-around: 40 interleaved push/pop pairs with incrementing data -> no data loss or reorder.
REQ-039 SHALL cover flush: flush with count=5 and wr asserted -> count=0, empty=1, the write is discarded, and error flags are preserved.
REQ-040 SHALL cover reset mid-fill: rstN low at count=7 -> all outputs at reset values; the next push lands at address 0 and reads back correctly in both FWFT modes.

Source files
------------

// File: rtl/definitions_pkg.sv
// definitions_pkg: shared UART sizing constants
package definitions_pkg;
  localparam int FIFO_DEPTH = 16;
  localparam int UART_DATA_W = 8;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage, synchronous write, combinational read
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  // write port, contents intentionally not reset
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: sync FIFO with flags and sticky errors; define UART_FIFO_FWFT_EN for first-word-fall-through reads
module uart_sync_fifo
  import definitions_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   flush,
  input  logic                   wr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;
  logic [DATA_W-1:0] mem_q;
  logic push, pop, ovf_evt, udf_evt;
  assign pop = rd & ~empty & ~flush;
  assign push = wr & (~full | pop) & ~flush;
  assign ovf_evt = wr & full & ~rd & ~flush;
  assign udf_evt = rd & empty & ~flush;
  assign count_nxt = flush ? '0 : count + CW'(push) - CW'(pop);
  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(push),
    .wr_addr(wr_ptr),
    .wr_data(wr_data),
    .rd_addr(rd_ptr),
    .rd_data(mem_q)
  );
  // pointers, occupancy and flags registered from the next-state count
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr <= flush ? '0 : wr_ptr + AW'(push);
      rd_ptr <= flush ? '0 : rd_ptr + AW'(pop);
      count <= count_nxt;
      full <= count_nxt == CW'(DEPTH);
      empty <= count_nxt == '0;
      almost_full <= count_nxt >= CW'(AF_THRESH);
      almost_empty <= count_nxt <= CW'(AE_THRESH);
    end
  // sticky errors: a new event beats clr_err, flush freezes both
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (!flush) begin
      overflow <= (overflow & ~clr_err) | ovf_evt;
      underflow <= (underflow & ~clr_err) | udf_evt;
    end
`ifdef UART_FIFO_FWFT_EN
  assign rd_valid = ~empty;
  assign rd_data = empty ? '0 : mem_q;
`else
  // registered read data with a one-cycle valid pulse per accepted pop
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_valid <= pop;
      if (pop) rd_data <= mem_q;
    end
`endif
endmodule
